// File: rtl/rv32_data_bus_bridge_pkg.sv
// Shared definitions for the rv32 data bus bridge: bus widths, FSM state codes
// and the store lane helper.
package rv32_data_bus_bridge_pkg;

    localparam int XLEN   = 32;
    localparam int MASK_W = XLEN / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Reads present an all-zero lane mask on the bus.
    function automatic logic [MASK_W-1:0] lane_mask(input logic write,
                                                    input logic [MASK_W-1:0] mask);
        return write ? mask : '0;
    endfunction

endpackage

// File: rtl/rv32_data_bus_bridge_timeout.sv
// Wait-state counter for the data bus bridge: counts enabled cycles and flags
// the cycle in which the LIMIT-th wait would be reached. LIMIT = 0 disables it.
module rv32_bus_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (LIMIT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
            localparam logic [W-1:0] LAST = W'(LIMIT - 1);

            logic [W-1:0] count;

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    count <= '0;
                end else if (enable) begin
                    count <= count + 1'b1;
                end
            end

            // Fires while the increment that would make count == LIMIT is pending.
            assign expired = enable && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/rv32_data_bus_bridge.sv
// Bridges rv32_mem's single-cycle data port to a req/ack system bus, stalling the
// pipeline until the transaction finishes and returning data/fault on release.
module rv32_data_bus_bridge
    import rv32_data_bus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              data_read_in,
    input  logic              data_write_in,
    input  logic [MASK_W-1:0] data_write_mask_in,
    input  logic [XLEN-1:0]   data_address_in,
    input  logic [XLEN-1:0]   data_write_value_in,
    output logic [XLEN-1:0]   data_read_value_out,
    output logic              data_fault_out,
    output logic              stall_out,
    output logic              bus_req_out,
    output logic              bus_write_out,
    output logic [XLEN-1:0]   bus_address_out,
    output logic [MASK_W-1:0] bus_write_mask_out,
    output logic [XLEN-1:0]   bus_write_value_out,
    input  logic              bus_ack_in,
    input  logic              bus_error_in,
    input  logic [XLEN-1:0]   bus_read_value_in
);

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic            access;
    logic            in_idle;
    logic            in_busy;
    logic            in_done;
    logic            waiting;
    logic            timed_out;
    logic [XLEN-1:0] read_value_q;
    logic            fault_q;

    assign access  = data_read_in | data_write_in;
    assign in_idle = (state == ST_IDLE);
    assign in_busy = (state == ST_BUSY);
    assign in_done = (state == ST_DONE);
    assign waiting = in_busy && !bus_ack_in;

    // Held clear throughout IDLE so every transaction starts from zero.
    rv32_bus_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (in_idle),
        .enable  (waiting),
        .expired (timed_out)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (access) state_next = ST_BUSY;
            ST_BUSY: if (bus_ack_in || timed_out) state_next = ST_DONE;
            ST_DONE: if (!stall_in) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= ST_IDLE;
            bus_write_out       <= 1'b0;
            bus_address_out     <= '0;
            bus_write_mask_out  <= '0;
            bus_write_value_out <= '0;
            read_value_q        <= '0;
            fault_q             <= 1'b0;
        end else begin
            state <= state_next;
            if (in_idle && access) begin
                bus_write_out       <= data_write_in;
                bus_address_out     <= data_address_in;
                bus_write_mask_out  <= lane_mask(data_write_in, data_write_mask_in);
                bus_write_value_out <= data_write_value_in;
            end
            // An ack in the expiry cycle wins over the timeout.
            if (in_busy && bus_ack_in) begin
                read_value_q <= bus_read_value_in;
                fault_q      <= bus_error_in;
            end else if (timed_out) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign bus_req_out         = in_busy;
    assign stall_out           = (in_idle && access) || in_busy;
    assign data_fault_out      = in_done && fault_q;
    assign data_read_value_out = read_value_q;

endmodule

// File: tb/tb_rv32_data_bus_bridge.sv
// Scoreboard bench for rv32_data_bus_bridge: one instance with the default
// timeout driven by a delay-programmable slave, one with TIMEOUT_CYCLES = 4.
module tb_rv32_data_bus_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall_in;
    logic        rd, wr;
    logic [3:0]  wmask;
    logic [31:0] addr, wval;
    logic [31:0] rval;
    logic        fault, stall, req, bwr;
    logic [31:0] baddr, bval;
    logic [3:0]  bmask;
    logic        ack, err;
    logic [31:0] brval;

    logic        t_rd, t_wr;
    logic [3:0]  t_wmask;
    logic [31:0] t_addr, t_wval;
    logic [31:0] t_rval;
    logic        t_fault, t_stall, t_req, t_bwr;
    logic [31:0] t_baddr, t_bval;
    logic [3:0]  t_bmask;
    logic        t_ack, t_err;
    logic [31:0] t_brval;

    rv32_data_bus_bridge dut (
        .clk(clk), .reset(reset), .stall_in(stall_in),
        .data_read_in(rd), .data_write_in(wr), .data_write_mask_in(wmask),
        .data_address_in(addr), .data_write_value_in(wval),
        .data_read_value_out(rval), .data_fault_out(fault), .stall_out(stall),
        .bus_req_out(req), .bus_write_out(bwr), .bus_address_out(baddr),
        .bus_write_mask_out(bmask), .bus_write_value_out(bval),
        .bus_ack_in(ack), .bus_error_in(err), .bus_read_value_in(brval)
    );

    rv32_data_bus_bridge #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset(reset), .stall_in(stall_in),
        .data_read_in(t_rd), .data_write_in(t_wr), .data_write_mask_in(t_wmask),
        .data_address_in(t_addr), .data_write_value_in(t_wval),
        .data_read_value_out(t_rval), .data_fault_out(t_fault), .stall_out(t_stall),
        .bus_req_out(t_req), .bus_write_out(t_bwr), .bus_address_out(t_baddr),
        .bus_write_mask_out(t_bmask), .bus_write_value_out(t_bval),
        .bus_ack_in(t_ack), .bus_error_in(t_err), .bus_read_value_in(t_brval)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] value;
        logic        fault;
        int          stall_len;
        int          req_len;
    } resp_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] value;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];

    int          slave_delay = 0;
    logic [31:0] slave_data  = '0;
    logic        slave_err   = 1'b0;

    // Bus slave for the main instance: acks on the (slave_delay+1)-th req cycle.
    initial begin
        int scnt;
        scnt  = 0;
        ack   = 1'b0;
        err   = 1'b0;
        brval = '0;
        forever begin
            @(posedge clk);
            #1;
            if (req) begin
                ack   = (scnt == slave_delay);
                err   = ack && slave_err;
                brval = ack ? slave_data : 32'h0;
                scnt++;
            end else begin
                scnt  = 0;
                ack   = 1'b0;
                err   = 1'b0;
                brval = '0;
            end
        end
    end

    // Response monitor: compares on the cycle stall_out falls (entry into DONE).
    initial begin
        logic  prev_stall, rst_pend;
        int    stall_run, req_run;
        resp_t e;
        prev_stall = 1'b0;
        rst_pend   = 1'b1;
        stall_run  = 0;
        req_run    = 0;
        forever begin
            @(negedge clk);
            if (rst_pend) begin
                stall_run = 0;
                req_run   = 0;
            end else begin
                if (stall) stall_run++;
                if (req) req_run++;
                if (prev_stall && !stall) begin
                    if (resp_q.size() == 0) begin
                        check("resp_unexpected", resp_q.size(), 1);
                    end else begin
                        e = resp_q.pop_front();
                        check("resp_value", rval, e.value);
                        check("resp_fault", {31'b0, fault}, {31'b0, e.fault});
                        check("resp_stall_len", stall_run, e.stall_len);
                        check("resp_req_len", req_run, e.req_len);
                    end
                    stall_run = 0;
                    req_run   = 0;
                end
            end
            prev_stall = stall;
            rst_pend   = reset;
        end
    end

    // Bus monitor: pops on req rise, then checks request fields every req cycle.
    initial begin
        logic prev_req;
        bus_t cur;
        prev_req  = 1'b0;
        cur.write = 1'b0;
        cur.addr  = '0;
        cur.mask  = '0;
        cur.value = '0;
        forever begin
            @(negedge clk);
            if (req && !prev_req) begin
                if (bus_q.size() == 0) check("bus_unexpected", bus_q.size(), 1);
                else cur = bus_q.pop_front();
            end
            if (req) begin
                check("bus_write", {31'b0, bwr}, {31'b0, cur.write});
                check("bus_addr", baddr, cur.addr);
                check("bus_mask", {28'b0, bmask}, {28'b0, cur.mask});
                check("bus_value", bval, cur.value);
            end
            prev_req = req;
        end
    end

    task automatic do_access(input logic w, input logic [31:0] a, input logic [3:0] m,
                             input logic [31:0] v, input logic [3:0] exp_mask,
                             input int delay, input logic [31:0] rdata, input logic rerr,
                             input logic [31:0] exp_val, input logic exp_fault,
                             input int exp_stall, input int exp_req, input int hold);
        resp_t r;
        bus_t  b;
        r.value = exp_val;  r.fault = exp_fault;
        r.stall_len = exp_stall;  r.req_len = exp_req;
        b.write = w;  b.addr = a;  b.mask = exp_mask;  b.value = v;
        resp_q.push_back(r);
        bus_q.push_back(b);
        slave_delay = delay;
        slave_data  = rdata;
        slave_err   = rerr;
        @(posedge clk);
        #1;
        rd = !w;  wr = w;  wmask = m;  addr = a;  wval = v;
        stall_in = (hold > 0);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (!stall) break;
        end
        check("release_wait", {31'b0, stall}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_value", rval, exp_val);
            check("hold_fault", {31'b0, fault}, {31'b0, exp_fault});
            check("hold_no_req", {31'b0, req}, 32'd0);
            @(posedge clk);
            #1;
        end
        stall_in = 1'b0;
        rd = 1'b0;  wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_fault", {31'b0, fault}, 32'd0);
        check("idle_req", {31'b0, req}, 32'd0);
        check("idle_stall", {31'b0, stall}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish required=finish");
        $fatal(1);
    end

    initial begin
        int rc;
        reset = 1'b1;  stall_in = 1'b0;
        rd = 1'b0;  wr = 1'b0;  wmask = '0;  addr = '0;  wval = '0;
        t_rd = 1'b0;  t_wr = 1'b0;  t_wmask = '0;  t_addr = '0;  t_wval = '0;
        t_ack = 1'b0;  t_err = 1'b0;  t_brval = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_req", {31'b0, req}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_rval", rval, 32'd0);
        check("rst_bwr", {31'b0, bwr}, 32'd0);
        check("rst_baddr", baddr, 32'd0);
        check("rst_bmask", {28'b0, bmask}, 32'd0);
        check("rst_bval", bval, 32'd0);
        check("rst_t_req", {31'b0, t_req}, 32'd0);
        check("rst_t_stall", {31'b0, t_stall}, 32'd0);

        // Zero-wait read; read lanes forced to 0 on the bus.
        do_access(1'b0, 32'h0000_1000, 4'hF, 32'h1234_5678, 4'h0,
                  0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 2, 1, 0);
        // Wait-state write, ack on the sixth req cycle.
        do_access(1'b1, 32'h0000_2004, 4'b0100, 32'h00AB_0000, 4'b0100,
                  5, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 1'b0, 7, 6, 0);
        // Bus error on a read.
        do_access(1'b0, 32'h0000_3000, 4'h0, 32'h0, 4'h0,
                  2, 32'h5555_AAAA, 1'b1, 32'h5555_AAAA, 1'b1, 4, 3, 0);
        // External stall holds DONE for three cycles with the access still presented.
        do_access(1'b0, 32'h0000_4008, 4'h0, 32'h0, 4'h0,
                  1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 3, 2, 3);
        @(negedge clk);
        check("no_reissue", {31'b0, req}, 32'd0);

        // Reset while BUSY: transaction abandoned, no response expected.
        begin
            bus_t b;
            b.write = 1'b0;  b.addr = 32'h0000_6000;  b.mask = 4'h0;  b.value = 32'h0;
            bus_q.push_back(b);
        end
        slave_delay = 20;
        @(posedge clk);
        #1;
        rd = 1'b1;  addr = 32'h0000_6000;  wval = 32'h0;  wmask = 4'h0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        rd = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_req", {31'b0, req}, 32'd0);
        check("midrst_stall", {31'b0, stall}, 32'd0);
        check("midrst_fault", {31'b0, fault}, 32'd0);
        check("midrst_rval", rval, 32'd0);

        do_access(1'b0, 32'h0000_5000, 4'h0, 32'h0, 4'h0,
                  0, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 1'b0, 2, 1, 0);

        // Timeout instance: no ack, expect four req cycles then a fault.
        @(posedge clk);
        #1;
        t_rd = 1'b1;  t_addr = 32'h0000_7000;
        rc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (t_req) rc++;
            if (!t_stall && i > 0) break;
            @(posedge clk);
            #1;
        end
        check("to_req_cycles", rc, 32'd4);
        check("to_fault", {31'b0, t_fault}, 32'd1);
        check("to_stall", {31'b0, t_stall}, 32'd0);
        @(posedge clk);
        #1;
        t_rd = 1'b0;
        t_ack = 1'b1;  t_err = 1'b1;  t_brval = 32'hFFFF_FFFF;
        @(negedge clk);
        check("late_ack_fault", {31'b0, t_fault}, 32'd0);
        check("late_ack_req", {31'b0, t_req}, 32'd0);
        @(posedge clk);
        #1;
        t_ack = 1'b0;  t_err = 1'b0;  t_brval = '0;
        @(negedge clk);
        check("late_ack_rval", t_rval, 32'd0);
        check("late_ack_stall", {31'b0, t_stall}, 32'd0);

        // Ack on the fourth wait cycle must beat a freshly cleared timeout.
        @(posedge clk);
        #1;
        t_rd = 1'b1;  t_addr = 32'h0000_7100;
        rc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!t_stall && i > 0) break;
            @(posedge clk);
            #1;
            if (t_req) begin
                rc++;
                t_ack   = (rc == 4);
                t_brval = (rc == 4) ? 32'h2468_ACE0 : 32'h0;
            end else begin
                t_ack   = 1'b0;
                t_brval = '0;
            end
        end
        check("to2_req_cycles", rc, 32'd4);
        check("to2_fault", {31'b0, t_fault}, 32'd0);
        check("to2_rval", t_rval, 32'h2468_ACE0);
        @(posedge clk);
        #1;
        t_rd = 1'b0;  t_ack = 1'b0;  t_brval = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("resp_q_empty", resp_q.size(), 32'd0);
        check("bus_q_empty", bus_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
